tpg_3bit_lfsr: RTL and testbench

Built-in self-test (BIST) test pattern generator that drives the 3-bit input vector of the circuit under test, for example {a, b, cin} of a 1-bit full adder. A 3-bit maximal-length Fibonacci LFSR steps through every non-zero pattern once. When the sequence is exhausted, the block freezes and raises `complete` so the response analyser and BIST controller can stop compaction.

---
 rtl/tpg_3bit_lfsr_if.sv | 14 +
 rtl/tpg_3bit_lfsr.sv | 87 ++++++++
 tb/tb_tpg_3bit_lfsr.sv | 138 +++++++++++++
 3 files changed

// File: rtl/tpg_3bit_lfsr_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tpg_3bit_lfsr_if
// Brief   : Pattern bus from the BIST pattern generator to the circuit under test.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface tpg_3bit_lfsr_if;
   logic [2:0] data_out;
   logic       complete;

   modport master (output data_out, output complete);
   modport slave  (input  data_out, input  complete);
endinterface
`default_nettype wire

// File: rtl/tpg_3bit_lfsr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tpg_3bit_lfsr
// Brief   : 3-bit maximal-length LFSR test pattern generator, freezes with
//           'complete' once every pattern has been emitted.
//           Optional macro TPG_ZERO_PATTERN_EN adds the all-zero pattern.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tpg_3bit_lfsr #(
   parameter logic [2:0] SEED = 3'b001
) (
   input  wire logic       clock,
   input  wire logic       reset,
   tpg_3bit_lfsr_if.master tpg
);

   // A zero seed would lock the LFSR, so it is promoted to 001.
   localparam logic [2:0] c_seed = (SEED == 3'b000) ? 3'b001 : SEED;
`ifdef TPG_ZERO_PATTERN_EN
   localparam logic [3:0] c_last = 4'd8;
`else
   localparam logic [3:0] c_last = 4'd7;
`endif

   logic [2:0] r_q;
   logic [3:0] r_cnt;
   logic       r_complete;

   logic [2:0] w_lfsr;
   logic [2:0] w_step;
   logic [2:0] w_q_nxt;
   logic [3:0] w_cnt_nxt;
   logic       w_complete_nxt;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         r_q        <= c_seed;
         r_cnt      <= 4'd1;
         r_complete <= 1'b0;
      end else begin
         r_q        <= w_q_nxt;
         r_cnt      <= w_cnt_nxt;
         r_complete <= w_complete_nxt;
      end
   end

   // Polynomial x^3 + x^2 + 1
   assign w_lfsr = {r_q[1:0], r_q[2] ^ r_q[1]};

`ifdef TPG_ZERO_PATTERN_EN
   // 000 is spliced in where the LFSR would wrap back to the seed.
   always_comb begin
      w_step = w_lfsr;
      if (r_q == 3'b000) begin
         w_step = c_seed;
      end else if (w_lfsr == c_seed) begin
         w_step = 3'b000;
      end
   end
`else
   assign w_step = w_lfsr;
`endif

   // Next-state logic
   always_comb begin
      w_q_nxt        = r_q;
      w_cnt_nxt      = r_cnt;
      w_complete_nxt = r_complete;
      if (!r_complete) begin
         if (r_cnt < c_last) begin
            w_q_nxt   = w_step;
            w_cnt_nxt = r_cnt + 4'd1;
         end else begin
            w_complete_nxt = 1'b1;
         end
      end
   end

   // Output logic
   always_comb begin
      tpg.data_out = r_q;
      tpg.complete = r_complete;
   end

endmodule
`default_nettype wire

// File: tb/tb_tpg_3bit_lfsr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_tpg_3bit_lfsr
// Brief   : Self-checking bench for tpg_3bit_lfsr (default seed and seed 110).
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_tpg_3bit_lfsr;

`ifdef TPG_ZERO_PATTERN_EN
   localparam int c_n = 8;
`else
   localparam int c_n = 7;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   tpg_3bit_lfsr_if bus0 ();
   tpg_3bit_lfsr_if bus1 ();

   tpg_3bit_lfsr dut0 (
      .clock (clock),
      .reset (reset),
      .tpg   (bus0)
   );

   tpg_3bit_lfsr #(.SEED(3'b110)) dut1 (
      .clock (clock),
      .reset (reset),
      .tpg   (bus1)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Model: pattern k of the set is the seed advanced k times by the
   // polynomial, with the zero pattern (when enabled) as the final entry.
   function automatic logic [2:0] poly_step(input logic [2:0] q);
      int v;
      v = int'(q);
      return 3'(((v * 2) % 8) + (((v / 4) + (v / 2)) % 2));
   endfunction

   function automatic logic [2:0] pat(input logic [2:0] seed, input int k);
      logic [2:0] q;
      if (k >= 7) return 3'b000;
      q = seed;
      for (int i = 0; i < k; i++) q = poly_step(q);
      return q;
   endfunction

   int idx      = 0;
   bit model_ok = 1'b0;

   always @(posedge clock) begin
      if (reset) begin
         idx      <= 0;
         model_ok <= 1'b1;
      end else if (idx < c_n) begin
         idx <= idx + 1;
      end
   end

   always @(negedge clock) begin
      if (model_ok) begin
         chk("model_d0", int'(bus0.data_out), int'(pat(3'b001, (idx < c_n) ? idx : c_n - 1)));
         chk("model_c0", int'(bus0.complete), (idx >= c_n) ? 1 : 0);
         chk("model_d1", int'(bus1.data_out), int'(pat(3'b110, (idx < c_n) ? idx : c_n - 1)));
         chk("model_c1", int'(bus1.complete), (idx >= c_n) ? 1 : 0);
      end
   end

   // Hand-computed pattern lists; entry 7 is only reached with the zero pattern.
   logic [2:0] lit0 [8] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
   logic [2:0] lit1 [8] = '{3'b110, 3'b100, 3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b000};

   task automatic edge_sample();
      @(posedge clock);
      #3;
   endtask

   // Checks cycles 1..cycles after a reset edge against the literal lists.
   task automatic run_check(input int cycles);
      int k;
      for (int c = 1; c <= cycles; c++) begin
         edge_sample();
         k = (c < c_n) ? c : c_n - 1;
         chk("lit_d0", int'(bus0.data_out), int'(lit0[k]));
         chk("lit_c0", int'(bus0.complete), (c >= c_n) ? 1 : 0);
         chk("lit_d1", int'(bus1.data_out), int'(lit1[k]));
         chk("lit_c1", int'(bus1.complete), (c >= c_n) ? 1 : 0);
      end
   endtask

   initial begin
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         edge_sample();
         chk("rst_hold_d0", int'(bus0.data_out), 1);
         chk("rst_hold_c0", int'(bus0.complete), 0);
         chk("rst_hold_d1", int'(bus1.data_out), 6);
      end
      reset = 1'b0;
      run_check(20);

      reset = 1'b1;
      edge_sample();
      chk("rst_done_d0", int'(bus0.data_out), 1);
      chk("rst_done_c0", int'(bus0.complete), 0);
      reset = 1'b0;
      edge_sample();
      edge_sample();
      edge_sample();
      chk("fourth_pat", int'(bus0.data_out), 3);

      reset = 1'b1;
      edge_sample();
      chk("rst_mid_d0", int'(bus0.data_out), 1);
      chk("rst_mid_c0", int'(bus0.complete), 0);
      reset = 1'b0;
      run_check(12);

      @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
